// File: rtl/i2c_target_ctrl.sv
// i2c_target_ctrl: I2C target endpoint, runs on clk100mhz and oversamples SCL/SDA.
// SCL/SDA pass through a 2-flop synchronizer and a FILTER_LEN stability filter.
// START/STOP, 7-bit address match and ACK are derived from the filtered levels.
// The open-drain pads are external; this block drives only the pull-low enables.
// Optional build macro I2C_CLK_STRETCH_EN: when a read byte is due and tx_valid=0,
// the block holds SCL low until tx_valid=1. Without the macro, scl_oe is 0 and the
// shifter is filled with 8'hFF.
module i2c_target_ctrl #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       clk100mhz,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_load,
  output logic       addr_hit,
  output logic       rw_bit,
  output logic       stop_det
);

`ifdef I2C_CLK_STRETCH_EN
  localparam logic STRETCH_EN = 1'b1;
`else
  localparam logic STRETCH_EN = 1'b0;
`endif

  localparam int            CW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] FLT_LOAD = CW'(FILTER_LEN - 1);

  // index 0 = SCL, index 1 = SDA
  logic [1:0]         s1, s2, flt, fltd;
  logic [1:0][CW-1:0] cnt;

  // synchronize, then accept a new level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      s1   <= 2'b11;
      s2   <= 2'b11;
      flt  <= 2'b11;
      fltd <= 2'b11;
      cnt  <= {2{FLT_LOAD}};
    end else begin
      s1   <= {sda_in, scl_in};
      s2   <= s1;
      fltd <= flt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == flt[i]) begin
          cnt[i] <= FLT_LOAD;
        end else if (cnt[i] == '0) begin
          flt[i] <= s2[i];
          cnt[i] <= FLT_LOAD;
        end else begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
  assign scl_f    = flt[0];
  assign sda_f    = flt[1];
  assign scl_rise = scl_f & ~fltd[0];
  assign scl_fall = ~scl_f & fltd[0];
  assign start_c  = scl_f & fltd[1] & ~sda_f;
  assign stop_c   = scl_f & ~fltd[1] & sda_f;

  // state    | meaning
  // IDLE     | bus free or unsynchronised, wait for START
  // ADDR     | shifting in address + R/W
  // ADDR_ACK | driving address ACK during 9th clock
  // WR_DATA  | shifting in a write byte
  // WR_ACK   | driving data ACK during 9th clock
  // RD_DATA  | driving read bits on each SCL fall
  // RD_ACK   | SDA released, sampling master ACK/NACK
  // IGNORE   | not addressed or read ended, wait for START/STOP
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t     state;
  logic [3:0] bitcnt;
  logic [7:0] shift;
  logic [7:0] shift_in, tx_byte;
  logic       stretch, load_pend;

  assign shift_in = {shift[6:0], sda_f};
  assign tx_byte  = tx_valid ? tx_data : 8'hFF;
  assign scl_oe   = STRETCH_EN & stretch;

  // protocol FSM; tx_load pulses only when real tx_data is taken (not for the 8'hFF fill)
  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shift     <= '0;
      sda_oe    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      addr_hit  <= 1'b0;
      rw_bit    <= 1'b0;
      stop_det  <= 1'b0;
      stretch   <= 1'b0;
      load_pend <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      stop_det <= 1'b0;
      if (stop_c) begin
        state     <= IDLE;
        bitcnt    <= '0;
        sda_oe    <= 1'b0;
        addr_hit  <= 1'b0;
        stop_det  <= 1'b1;
        stretch   <= 1'b0;
        load_pend <= 1'b0;
      end else if (start_c) begin
        state     <= ADDR;
        bitcnt    <= '0;
        sda_oe    <= 1'b0;
        addr_hit  <= 1'b0;
        stretch   <= 1'b0;
        load_pend <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift  <= shift_in;
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                if (shift[6:0] == TARGET_ADDR) rw_bit <= sda_f;
                else                           state  <= IGNORE;
              end
            end else if (scl_fall && bitcnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              addr_hit <= 1'b1;
              bitcnt   <= '0;
              if (!rw_bit) begin
                sda_oe <= 1'b0;
                state  <= WR_DATA;
              end else begin
                state <= RD_DATA;
                if (STRETCH_EN && !tx_valid) begin
                  sda_oe  <= 1'b0;
                  stretch <= 1'b1;
                end else begin
                  sda_oe  <= ~tx_byte[7];
                  shift   <= {tx_byte[6:0], 1'b0};
                  tx_load <= tx_valid;
                  bitcnt  <= 4'd1;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift  <= shift_in;
              bitcnt <= bitcnt + 4'd1;
              if (bitcnt == 4'd7) begin
                rx_data  <= shift_in;
                rx_valid <= 1'b1;
              end
            end else if (scl_fall && bitcnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              bitcnt <= '0;
              state  <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (stretch) begin
              if (tx_valid) begin
                stretch <= 1'b0;
                sda_oe  <= ~tx_byte[7];
                shift   <= {tx_byte[6:0], 1'b0};
                tx_load <= 1'b1;
                bitcnt  <= 4'd1;
              end
            end else if (scl_fall) begin
              if (load_pend) begin
                load_pend <= 1'b0;
                if (tx_valid) begin
                  sda_oe  <= ~tx_byte[7];
                  shift   <= {tx_byte[6:0], 1'b0};
                  tx_load <= 1'b1;
                  bitcnt  <= 4'd1;
                end else begin
                  stretch <= 1'b1;
                end
              end else if (bitcnt == 4'd8) begin
                sda_oe <= 1'b0;
                bitcnt <= '0;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~shift[7];
                shift  <= {shift[6:0], 1'b0};
                bitcnt <= bitcnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                state  <= RD_DATA;
                bitcnt <= '0;
                // with stretching the load is deferred to the fall, where SCL can be held
                if (STRETCH_EN) begin
                  load_pend <= 1'b1;
                end else begin
                  shift   <= tx_byte;
                  tx_load <= tx_valid;
                end
              end else begin
                state <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
